apu_length_counter_bank: RTL and testbench

Parametrised bank of NES APU length counters: one 8-bit down-counter per channel (default four: pulse 1, pulse 2, triangle, noise), all loaded through one shared write port and decremented on the frame sequencer's half-frame clock. It sits between the APU register decode ($4003/$4007/$400B/$400F writes, $4015 enable mask) and the channel gating logic. It also supplies the $4015 status bits. Compared with the single-channel counter, it adds internal edge detection, a shared write port, a status vector, and optional hardware-accurate write/clock collision behaviour.

---
 rtl/apu_pkg.sv | 22 ++
 rtl/apu_lc_channel.sv | 66 ++++++
 rtl/apu_length_counter_bank.sv | 54 +++++
 tb/tb_apu_length_counter_bank.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/apu_pkg.sv
// Shared NES APU length-counter definitions: load table, lookup, channel ids.
package apu_pkg;

  typedef enum logic [1:0] {
    PULSE1 = 2'd0,
    PULSE2 = 2'd1,
    TRI    = 2'd2,
    NOISE  = 2'd3
  } apu_ch_e;

  localparam logic [7:0] LC_TABLE [32] = '{
    8'd10,  8'd254, 8'd20, 8'd2,  8'd40, 8'd4,  8'd80, 8'd6,
    8'd160, 8'd8,   8'd60, 8'd10, 8'd14, 8'd12, 8'd26, 8'd14,
    8'd12,  8'd16,  8'd24, 8'd18, 8'd48, 8'd20, 8'd96, 8'd22,
    8'd192, 8'd24,  8'd72, 8'd26, 8'd16, 8'd28, 8'd32, 8'd30
  };

  function automatic logic [7:0] lc_lookup(input logic [4:0] idx);
    return LC_TABLE[idx];
  endfunction

endpackage

// File: rtl/apu_lc_channel.sv
// One APU length counter with load/disable/tick priority.
// APU_LC_QUIRKS_EN selects 2A03 collision and registered-halt behaviour.
module apu_lc_channel
  import apu_pkg::*;
#(
  parameter int COUNT_W = 8
) (
  input  logic               cpu_clk,
  input  logic               reset_n,
  input  logic               en,
  input  logic               ld,
  input  logic               tick,
  input  logic               halt,
  input  logic [4:0]         idx,
  output logic [COUNT_W-1:0] count
);

  logic               halt_eff;
  logic               dec_ok;
  logic [COUNT_W-1:0] ld_val;
  logic [COUNT_W-1:0] count_nxt;

  assign ld_val = COUNT_W'(lc_lookup(idx));
  assign dec_ok = tick & ~halt_eff & (count != '0);

`ifdef APU_LC_QUIRKS_EN
  logic halt_q;

  always_ff @(posedge cpu_clk or negedge reset_n) begin
    if (!reset_n) halt_q <= 1'b0;
    else          halt_q <= halt;
  end

  assign halt_eff = halt_q;
`else
  assign halt_eff = halt;
`endif

  always_comb begin
    count_nxt = count;
    if (!en) begin
      count_nxt = '0;
    end else if (ld & tick) begin
`ifdef APU_LC_QUIRKS_EN
      // A running counter drops the load and takes the tick
      if (count != '0) begin
        if (dec_ok) count_nxt = count - COUNT_W'(1);
      end else begin
        count_nxt = ld_val;
      end
`else
      count_nxt = ld_val;
`endif
    end else if (ld) begin
      count_nxt = ld_val;
    end else if (dec_ok) begin
      count_nxt = count - COUNT_W'(1);
    end
  end

  always_ff @(posedge cpu_clk or negedge reset_n) begin
    if (!reset_n) count <= '0;
    else          count <= count_nxt;
  end

endmodule

// File: rtl/apu_length_counter_bank.sv
// Bank of NES APU length counters with shared write port and tick detect.
// Optional 2A03 collision/halt quirks via APU_LC_QUIRKS_EN.
module apu_length_counter_bank
  import apu_pkg::*;
#(
  parameter  int NUM_CH  = 4,
  parameter  int COUNT_W = 8,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                      cpu_clk,
  input  logic                      reset_n,
  input  logic                      half_clk,
  input  logic                      wr_en,
  input  logic [CH_W-1:0]           wr_ch,
  input  logic [4:0]                wr_idx,
  input  logic [NUM_CH-1:0]         enable,
  input  logic [NUM_CH-1:0]         halt,
  output logic [NUM_CH*COUNT_W-1:0] count,
  output logic [NUM_CH-1:0]         active
);

  logic half_clk_q;
  logic tick;

  always_ff @(posedge cpu_clk or negedge reset_n) begin
    if (!reset_n) half_clk_q <= 1'b0;
    else          half_clk_q <= half_clk;
  end

  assign tick = half_clk & ~half_clk_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic ld;

    // Out-of-range channel numbers match no instance
    assign ld = wr_en & (wr_ch == CH_W'(i));

    apu_lc_channel #(
      .COUNT_W (COUNT_W)
    ) u_ch (
      .cpu_clk (cpu_clk),
      .reset_n (reset_n),
      .en      (enable[i]),
      .ld      (ld),
      .tick    (tick),
      .halt    (halt[i]),
      .idx     (wr_idx),
      .count   (count[i*COUNT_W +: COUNT_W])
    );

    assign active[i] = |count[i*COUNT_W +: COUNT_W];
  end

endmodule

// File: tb/tb_apu_length_counter_bank.sv
// Scoreboard bench for apu_length_counter_bank: directed plan plus random traffic.
// Reference model follows the counter rules with plain integer arithmetic.
module tb_apu_length_counter_bank;

  localparam int N = 4;
  localparam int W = 8;

  logic           cpu_clk  = 1'b0;
  logic           reset_n  = 1'b0;
  logic           half_clk = 1'b0;
  logic           wr_en    = 1'b0;
  logic [1:0]     wr_ch    = '0;
  logic [4:0]     wr_idx   = '0;
  logic [N-1:0]   enable   = '0;
  logic [N-1:0]   halt     = '0;
  logic [N*W-1:0] count;
  logic [N-1:0]   active;

  always #5 cpu_clk = ~cpu_clk;

  apu_length_counter_bank #(
    .NUM_CH  (N),
    .COUNT_W (W)
  ) dut (
    .cpu_clk  (cpu_clk),
    .reset_n  (reset_n),
    .half_clk (half_clk),
    .wr_en    (wr_en),
    .wr_ch    (wr_ch),
    .wr_idx   (wr_idx),
    .enable   (enable),
    .halt     (halt),
    .count    (count),
    .active   (active)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [N*W-1:0] cnt;
    logic [N-1:0]   act;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  int tbl[32] = '{10, 254, 20, 2, 40, 4, 80, 6, 160, 8, 60, 10, 14, 12, 26, 14,
                  12, 16, 24, 18, 48, 20, 96, 22, 192, 24, 72, 26, 16, 28, 32, 30};
  int m_cnt[N];
  int m_hq[N];
  int m_hc;

  // Advance the model by one clock edge using the inputs now on the pins
  task automatic model_step();
    bit tk;
    bit ld;
    bit heff;
    if (!reset_n) begin
      for (int i = 0; i < N; i++) begin
        m_cnt[i] = 0;
        m_hq[i]  = 0;
      end
      m_hc = 0;
      return;
    end
    tk = half_clk && (m_hc == 0);
    for (int i = 0; i < N; i++) begin
      ld = wr_en && (int'(wr_ch) == i);
`ifdef APU_LC_QUIRKS_EN
      heff = (m_hq[i] != 0);
`else
      heff = halt[i];
`endif
      if (!enable[i]) m_cnt[i] = 0;
      else if (ld && tk) begin
`ifdef APU_LC_QUIRKS_EN
        if (m_cnt[i] > 0) begin
          if (!heff) m_cnt[i] = m_cnt[i] - 1;
        end else m_cnt[i] = tbl[wr_idx];
`else
        m_cnt[i] = tbl[wr_idx];
`endif
      end else if (ld) m_cnt[i] = tbl[wr_idx];
      else if (tk && !heff && m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
      m_hq[i] = halt[i];
    end
    m_hc = half_clk;
  endtask

  task automatic push_exp();
    exp_t e;
    for (int i = 0; i < N; i++) begin
      e.cnt[i*W +: W] = W'(m_cnt[i]);
      e.act[i]        = (m_cnt[i] != 0);
    end
    q.push_back(e);
  endtask

  task automatic cyc(input bit we, input int ch, input int idx, input bit hc);
    @(negedge cpu_clk);
    wr_en    = we;
    wr_ch    = 2'(ch);
    wr_idx   = 5'(idx);
    half_clk = hc;
    model_step();
    push_exp();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic do_tick();
    cyc(1'b0, 0, 0, 1'b1);
    cyc(1'b0, 0, 0, 1'b0);
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic int cnt_of(input int ch);
    return int'(count[ch*W +: W]);
  endfunction

  always @(posedge cpu_clk) begin
    #2;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      for (int i = 0; i < N; i++) begin
        checks++;
        if (count[i*W +: W] !== mon_e.cnt[i*W +: W]) begin
          failures++;
          $display("FAIL sb_count%0d @%0t: got %0d expected %0d", i, $time,
                   count[i*W +: W], mon_e.cnt[i*W +: W]);
        end
      end
      checks++;
      if (active !== mon_e.act) begin
        failures++;
        $display("FAIL sb_active @%0t: got %b expected %b", $time, active, mon_e.act);
      end
    end
  end

  initial begin
    int c0;
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 0;
      m_hq[i]  = 0;
    end
    m_hc = 0;

    repeat (3) cyc(1'b0, 0, 0, 1'b0);
    chk("reset_count", int'(count), 0);
    chk("reset_active", int'(active), 0);

    @(negedge cpu_clk);
    reset_n = 1'b1;
    enable  = 4'hF;

    cyc(1'b1, 0, 1, 1'b0);
    chk("load_254", cnt_of(0), 254);
    chk("active_0001", int'(active), 1);
    repeat (3) do_tick();
    chk("three_ticks", cnt_of(0), 251);
    halt[0] = 1'b1;
    cyc(1'b0, 0, 0, 1'b0);
    do_tick();
    chk("halt_hold", cnt_of(0), 251);
    halt[0] = 1'b0;

    cyc(1'b1, 2, 0, 1'b0);
    chk("load_10", cnt_of(2), 10);
    repeat (10) do_tick();
    chk("ten_ticks", cnt_of(2), 0);
    chk("active2_fall", int'(active[2]), 0);
    do_tick();
    chk("zero_sticky", cnt_of(2), 0);

    cyc(1'b1, 1, 2, 1'b0);
    chk("load_20", cnt_of(1), 20);
    enable[1] = 1'b0;
    cyc(1'b1, 1, 31, 1'b0);
    chk("disable_beats_load", cnt_of(1), 0);
    cyc(1'b1, 1, 5, 1'b0);
    chk("load_while_disabled", cnt_of(1), 0);
    enable[1] = 1'b1;

    cyc(1'b1, 3, 7, 1'b0);
    chk("load_6", cnt_of(3), 6);
    cyc(1'b1, 3, 31, 1'b1);
`ifdef APU_LC_QUIRKS_EN
    chk("collision_running", cnt_of(3), 5);
`else
    chk("collision_running", cnt_of(3), 30);
`endif
    cyc(1'b0, 0, 0, 1'b0);
    enable[3] = 1'b0;
    cyc(1'b0, 0, 0, 1'b0);
    enable[3] = 1'b1;
    cyc(1'b1, 3, 31, 1'b1);
    chk("collision_zero", cnt_of(3), 30);
    cyc(1'b0, 0, 0, 1'b0);

    cyc(1'b1, 0, 4, 1'b0);
    chk("load_40", cnt_of(0), 40);
    halt[0] = 1'b1;
    cyc(1'b0, 0, 0, 1'b1);
`ifdef APU_LC_QUIRKS_EN
    chk("halt_same_tick", cnt_of(0), 39);
`else
    chk("halt_same_tick", cnt_of(0), 40);
`endif
    c0 = cnt_of(0);
    cyc(1'b0, 0, 0, 1'b0);
    do_tick();
    chk("halt_next_tick", cnt_of(0), c0);
    halt[0] = 1'b0;
    cyc(1'b0, 0, 0, 1'b0);
    repeat (5) cyc(1'b0, 0, 0, 1'b1);
    cyc(1'b0, 0, 0, 1'b0);
    chk("held_high_one_tick", cnt_of(0), c0 - 1);

    @(negedge cpu_clk);
    reset_n = 1'b0;
    #1;
    chk("async_reset", int'(count), 0);
    cyc(1'b0, 0, 0, 1'b0);
    @(negedge cpu_clk);
    reset_n = 1'b1;

    for (int k = 0; k < 600; k++) begin
      enable = ($urandom_range(0, 15) == 0) ? N'($urandom) : 4'hF;
      halt   = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      cyc(($urandom_range(0, 2) == 0), int'($urandom_range(0, 3)),
          int'($urandom_range(0, 31)), ($urandom_range(0, 2) == 0));
    end

    repeat (3) @(posedge cpu_clk);
    #3;
    chk("scoreboard_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
